// File: rtl/stopwatch_core.sv
// Stopwatch counting core: MM:SS BCD counter with run / pause / adjust modes.
// Counting is strobed by tick_1hz, manual adjustment by tick_2hz. The pause
// flag is separate from the mode state so that it survives a trip through
// adjust mode. The clear input zeroes the time and the pause flag.
module stopwatch_core #(
  parameter int MIN_MAX = 59,
  parameter int SEC_MAX = 59
) (
  input  logic       clk_100mhz,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       tick_2hz,
  input  logic       clr,
  input  logic       pause_lvl,
  input  logic       adj,
  input  logic       sel,
  output logic [3:0] mt,
  output logic [3:0] mo,
  output logic [3:0] st,
  output logic [3:0] so,
  output logic       paused,
  output logic       blink_min,
  output logic       blink_sec
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_PAUSE = 2'd1,
    S_ADJ   = 2'd2
  } state_t;

  // Wrap limits expressed as packed BCD so they compare directly with the digits.
  localparam logic [7:0] MIN_MAX_BCD = {4'(MIN_MAX / 10), 4'(MIN_MAX % 10)};
  localparam logic [7:0] SEC_MAX_BCD = {4'(SEC_MAX / 10), 4'(SEC_MAX % 10)};

  state_t     state;
  logic       p;
  logic       pause_q;
  logic       pe;
  logic       p_nxt;
  state_t     state_nxt;
  logic [7:0] min_q;
  logic [7:0] sec_q;

  // Increment a two-digit packed BCD value, wrapping to 00 past max_bcd.
  // The ones digit rolls 9 -> 0 with a carry into the tens digit, so the
  // result is always valid BCD as long as max_bcd itself is.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max_bcd);
    logic [7:0] r;
    if (v == max_bcd) begin
      r = 8'h00;
    end else if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  // True when an increment of v would wrap back to 00.
  function automatic logic bcd_at_max(input logic [7:0] v, input logic [7:0] max_bcd);
    return (v == max_bcd);
  endfunction

  // Rising edge of the pause button; pause_q resets high so a button held
  // through reset release does not count as a press.
  assign pe = pause_lvl & ~pause_q;

  // Pause flag as it will be after this edge; clear forces it low.
  assign p_nxt = clr ? 1'b0 : (p ^ pe);

  // Mode selection uses the post-toggle pause flag so a press is reflected
  // in the mode on the same edge that flips the flag.
  always_comb begin
    state_nxt = S_RUN;
    if (adj) begin
      state_nxt = S_ADJ;
    end else if (p_nxt) begin
      state_nxt = S_PAUSE;
    end else begin
      state_nxt = S_RUN;
    end
  end

  // Mode state, pause tracking, time digits and registered status outputs.
  always_ff @(posedge clk_100mhz) begin
    if (!rst_n) begin
      state     <= S_RUN;
      p         <= 1'b0;
      pause_q   <= 1'b1;
      min_q     <= 8'h00;
      sec_q     <= 8'h00;
      blink_min <= 1'b0;
      blink_sec <= 1'b0;
    end else begin
      pause_q   <= pause_lvl;
      p         <= p_nxt;
      state     <= state_nxt;
      blink_sec <= (state_nxt == S_ADJ) & sel;
      blink_min <= (state_nxt == S_ADJ) & ~sel;
      if (clr) begin
        min_q <= 8'h00;
        sec_q <= 8'h00;
      end else begin
        case (state)
          S_RUN: begin
            if (tick_1hz) begin
              sec_q <= bcd_inc(sec_q, SEC_MAX_BCD);
              if (bcd_at_max(sec_q, SEC_MAX_BCD)) begin
                min_q <= bcd_inc(min_q, MIN_MAX_BCD);
              end
            end
          end
          S_ADJ: begin
            if (tick_2hz) begin
              if (sel) begin
                sec_q <= bcd_inc(sec_q, SEC_MAX_BCD);
              end else begin
                min_q <= bcd_inc(min_q, MIN_MAX_BCD);
              end
            end
          end
          default: begin
            min_q <= min_q;
            sec_q <= sec_q;
          end
        endcase
      end
    end
  end

  assign mt     = min_q[7:4];
  assign mo     = min_q[3:0];
  assign st     = sec_q[7:4];
  assign so     = sec_q[3:0];
  assign paused = p;

endmodule
